// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 convolution with line buffers and one shared 9-tap MAC
module conv3x3_stream #(
  parameter int IMG_W    = 12,
  parameter int IMG_H    = 12,
  parameter int PIX_W    = 2,
  parameter int COEF_W   = 2,
  parameter int OUT_W    = 2,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9*COEF_W-1:0]   filter,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIX_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_last
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int SUM_W = PIX_W + COEF_W + 4;
  localparam int EXT_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
  localparam logic [EXT_W-1:0] MAX_EXT = {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic [9*COEF_W-1:0]    filt_q, filt_d;
  logic [PIX_W-1:0]       lb0_q [IMG_W];
  logic [PIX_W-1:0]       lb0_d [IMG_W];
  logic [PIX_W-1:0]       lb1_q [IMG_W];
  logic [PIX_W-1:0]       lb1_d [IMG_W];
  logic [PIX_W-1:0]       win_q [3][3];
  logic [PIX_W-1:0]       win_d [3][3];
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_last_q, s1_last_d;
  logic                   s2_valid_q, s2_valid_d;
  logic                   s2_last_q, s2_last_d;
  logic [OUT_W-1:0]       s2_data_q, s2_data_d;

  logic                   s2_load;
  logic                   accept;
  logic                   last_col;
  logic                   last_row;
  logic                   produce;
  logic [SUM_W-1:0]       sum;
  logic [EXT_W-1:0]       sum_ext;
  logic [OUT_W-1:0]       result;

  assign s2_load   = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_load;
  assign accept    = in_valid && in_ready;
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_row  = (row_q == RW'(IMG_H - 1));
  assign produce   = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_last  = s2_last_q;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    filt_d = filt_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (row_q == '0 && col_q == '0) begin
        filt_d = filter;
      end
    end
  end

  // Line buffers are read before write: the old entry at this column is the pixel one row up.
  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    win_d = win_q;
    if (accept) begin
      lb0_d[col_q] = in_data;
      lb1_d[col_q] = lb0_q[col_q];
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb1_q[col_q];
      win_d[1][2] = lb0_q[col_q];
      win_d[2][2] = in_data;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        sum = sum + SUM_W'(win_q[i][j]) * SUM_W'(filt_q[COEF_W*(3*i+j) +: COEF_W]);
      end
    end
    sum_ext = EXT_W'(sum);
    result  = sum_ext[OUT_W-1:0];
    if (SATURATE != 0 && sum_ext > MAX_EXT) begin
      result = MAX_EXT[OUT_W-1:0];
    end
  end

  // S1 is the window itself; it may only shift once its pending result has moved to S2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_data_d  = s2_data_q;
    if (accept) begin
      s1_valid_d = produce;
      s1_last_d  = last_row && last_col;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        s2_data_d = result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      filt_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      filt_q     <= filt_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_data_q  <= s2_data_d;
    end
  end

  always_ff @(posedge clk) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
    win_q <= win_d;
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - directed self-checking bench for conv3x3_stream
module tb_conv3x3_stream;

  localparam logic [17:0] ONES   = 18'h15555;
  localparam logic [17:0] CENTRE = 18'h00100;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] filter;
  logic        in_valid;
  logic [1:0]  in_data;
  logic        out_ready;
  logic        in_ready, out_valid, out_last;
  logic [1:0]  out_data;
  logic        in_ready_w, out_valid_w, out_last_w;
  logic [1:0]  out_data_w;

  int tests = 0;
  int fails = 0;
  int res_q[$];
  int resw_q[$];
  bit last_q[$];

  always #5 clk = ~clk;

  conv3x3_stream #(.SATURATE(1)) dut (
    .clk(clk), .rst(rst), .filter(filter),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  conv3x3_stream #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .filter(filter),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w), .out_last(out_last_w)
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      res_q.push_back(int'(out_data));
      last_q.push_back(out_last);
    end
    if (!rst && out_valid_w && out_ready) begin
      resw_q.push_back(int'(out_data_w));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [1:0] pix(input int mode, input int r, input int c);
    if (mode == 0) return 2'd1;
    return 2'((r + c) % 4);
  endfunction

  task automatic clear_queues();
    res_q.delete();
    resw_q.delete();
    last_q.delete();
  endtask

  task automatic drive_pixel(input logic [1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL drive_timeout in_ready stuck low");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int mode);
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++)
        drive_pixel(pix(mode, r, c));
  endtask

  task automatic drain(input int want);
    int n = 0;
    in_valid = 1'b0;
    while (res_q.size() < want && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (res_q.size() != want) begin
      fails++;
      $display("FAIL result_count got %0d want %0d", res_q.size(), want);
    end
    tests++;
    if (resw_q.size() != want) begin
      fails++;
      $display("FAIL wrap_result_count got %0d want %0d", resw_q.size(), want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; filter = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++;
    if (out_data !== 2'd0) begin fails++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    tests++;
    if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b want 0", out_last); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_sat_ones();
    filter = ONES;
    clear_queues();
    for (int k = 0; k < 144; k++) begin
      drive_pixel(2'd1);
      if (k == 26) begin
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_early got %b want 0", out_valid); end
      end
      if (k == 27) begin
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL latency_first got %b want 1", out_valid); end
      end
    end
    drain(100);
    for (int k = 0; k < res_q.size(); k++) begin
      tests++;
      if (res_q[k] != 3) begin fails++; $display("FAIL sat_ones[%0d] got %0d want 3", k, res_q[k]); end
      tests++;
      if (last_q[k] != (k == 99)) begin fails++; $display("FAIL sat_last[%0d] got %b want %b", k, last_q[k], k == 99); end
    end
  endtask

  task automatic test_wrap_ones();
    filter = ONES;
    clear_queues();
    send_frame(0);
    drain(100);
    for (int k = 0; k < resw_q.size(); k++) begin
      tests++;
      if (resw_q[k] != 1) begin fails++; $display("FAIL wrap_ones[%0d] got %0d want 1", k, resw_q[k]); end
    end
  endtask

  task automatic test_centre();
    filter = CENTRE;
    clear_queues();
    send_frame(1);
    drain(100);
    for (int k = 0; k < res_q.size(); k++) begin
      tests++;
      if (res_q[k] != ((k / 10) + (k % 10) + 2) % 4) begin
        fails++;
        $display("FAIL centre[%0d] got %0d want %0d", k, res_q[k], ((k / 10) + (k % 10) + 2) % 4);
      end
    end
    for (int k = 0; k < resw_q.size(); k++) begin
      tests++;
      if (resw_q[k] != ((k / 10) + (k % 10) + 2) % 4) begin
        fails++;
        $display("FAIL centre_wrap[%0d] got %0d want %0d", k, resw_q[k], ((k / 10) + (k % 10) + 2) % 4);
      end
    end
  endtask

  task automatic stall_output();
    int n = 0;
    logic [1:0] held;
    while (res_q.size() < 25 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    held = 2'd0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (s == 0) held = out_data;
      tests++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b want 1", s, out_valid); end
      tests++;
      if (out_data !== held) begin fails++; $display("FAIL stall_data[%0d] got %0d want %0d", s, out_data, held); end
      if (s == 1) begin
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic test_backpressure();
    filter = CENTRE;
    clear_queues();
    fork
      send_frame(1);
      stall_output();
    join
    drain(100);
    for (int k = 0; k < res_q.size(); k++) begin
      tests++;
      if (res_q[k] != ((k / 10) + (k % 10) + 2) % 4) begin
        fails++;
        $display("FAIL bp[%0d] got %0d want %0d", k, res_q[k], ((k / 10) + (k % 10) + 2) % 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    filter = ONES;
    clear_queues();
    for (int k = 0; k < 30; k++) drive_pixel(2'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    tests++;
    if (out_last !== 1'b0) begin fails++; $display("FAIL midrst_last got %b want 0", out_last); end
    clear_queues();
    filter = CENTRE;
    send_frame(1);
    drain(100);
    for (int k = 0; k < res_q.size(); k++) begin
      tests++;
      if (res_q[k] != ((k / 10) + (k % 10) + 2) % 4) begin
        fails++;
        $display("FAIL midrst[%0d] got %0d want %0d", k, res_q[k], ((k / 10) + (k % 10) + 2) % 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lasts = 0;
    filter = ONES;
    clear_queues();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++) begin
          drive_pixel(2'd1);
          if (f == 0 && r == 6 && c == 0) filter = '0;
        end
    drain(200);
    for (int k = 0; k < res_q.size(); k++) begin
      tests++;
      if (res_q[k] != ((k < 100) ? 3 : 0)) begin
        fails++;
        $display("FAIL b2b[%0d] got %0d want %0d", k, res_q[k], (k < 100) ? 3 : 0);
      end
      tests++;
      if (last_q[k] != (k == 99 || k == 199)) begin
        fails++;
        $display("FAIL b2b_last[%0d] got %b want %b", k, last_q[k], k == 99 || k == 199);
      end
      if (last_q[k]) lasts++;
    end
    tests++;
    if (lasts != 2) begin fails++; $display("FAIL b2b_last_count got %0d want 2", lasts); end
  endtask

  initial begin
    test_reset();
    test_sat_ones();
    test_wrap_ones();
    test_centre();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
